// File: rtl/hdma_multi_if.sv
// Bus bundle for hdma_multi: CPU register window, LCD mode, bus stall and the
// copy-engine outputs toward the VRAM bus mux.
`timescale 1ns/1ps
interface hdma_multi_if #(
  parameter int NCH = 2
) ();
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           sel_reg;
  logic [CHW+3:0] addr;
  logic           wr;
  logic [7:0]     din;
  logic [7:0]     dout;
  logic [1:0]     lcd_mode;
  logic           dma_wait;
  logic           hdma_rd;
  logic [15:0]    hdma_source_addr;
  logic [15:0]    hdma_target_addr;
  logic [CHW-1:0] hdma_ch;
  logic [NCH-1:0] ch_busy;

  modport master (
    output sel_reg, addr, wr, din, lcd_mode, dma_wait,
    input  dout, hdma_rd, hdma_source_addr, hdma_target_addr, hdma_ch, ch_busy
  );

  modport slave (
    input  sel_reg, addr, wr, din, lcd_mode, dma_wait,
    output dout, hdma_rd, hdma_source_addr, hdma_target_addr, hdma_ch, ch_busy
  );
endinterface

// File: rtl/hdma_multi.sv
// Multi-channel GDMA/HDMA engine: NCH register windows sharing one copy engine
// that is arbitrated (lowest index first) at every block boundary.
`timescale 1ns/1ps
module hdma_multi #(
  parameter int NCH          = 2,
  parameter int BLOCK_BYTES  = 16,
  parameter int CYC_PER_BYTE = 2
) (
  input logic         clk,
  input logic         reset,
  hdma_multi_if.slave bus
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW  = (CYC_PER_BYTE > 1) ? $clog2(CYC_PER_BYTE) : 1;
  localparam int BW  = $clog2(BLOCK_BYTES);

  typedef enum logic [1:0] {H_WAIT = 2'd0, H_ACTIVE = 2'd1, H_SENT = 2'd2} hstate_t;
  typedef enum logic {E_IDLE = 1'b0, E_XFER = 1'b1} estate_t;

  logic [7:0]     src_h     [NCH];
  logic [3:0]     src_l     [NCH];
  logic [4:0]     dst_h     [NCH];
  logic [3:0]     dst_l     [NCH];
  logic [7:0]     remaining [NCH];
  hstate_t        hstate    [NCH];
  logic [15:0]    work_src  [NCH];
  logic [12:0]    work_dst  [NCH];
  logic [NCH-1:0] enabled;
  logic [NCH-1:0] mode;

  estate_t        state;
  logic           rd;
  logic [CHW-1:0] cur_ch;
  logic [SW-1:0]  sub;
  logic [BW-1:0]  bcnt;
  logic [15:0]    src_hold;
  logic [15:0]    dst_hold;

  logic [CHW-1:0] ch_sel;
  logic [3:0]     reg_sel;
  logic           ch_ok, wr_en, ctrl_wr, granted_wr, cancel, cancel_granted, trigger;
  logic           step, byte_done, blk_done;
  logic [NCH-1:0] ready;
  logic           any_ready;
  logic [CHW-1:0] pick;
  logic [7:0]     rdata;

  assign ch_sel  = bus.addr[CHW+3:4];
  assign reg_sel = bus.addr[3:0];

  // Write decode and engine progress strobes; a cancel of the granted channel outranks dma_wait.
  always_comb begin
    ch_ok          = (int'(ch_sel) < NCH);
    wr_en          = bus.sel_reg & bus.wr & ch_ok;
    ctrl_wr        = wr_en & (reg_sel == 4'd5);
    granted_wr     = (state == E_XFER) & (cur_ch == ch_sel);
    cancel         = ctrl_wr & enabled[ch_sel] & mode[ch_sel] & ~bus.din[7];
    cancel_granted = cancel & granted_wr;
    trigger        = ctrl_wr & ~cancel & ~granted_wr;
    step           = (state == E_XFER) & ~cancel_granted & ~bus.dma_wait;
    byte_done      = step & (sub == SW'(CYC_PER_BYTE - 1));
    blk_done       = byte_done & (bcnt == BW'(BLOCK_BYTES - 1));
  end

  // Fixed-priority arbitration; a channel whose ctrl is being written this cycle sits out.
  always_comb begin
    ready     = {NCH{1'b0}};
    any_ready = 1'b0;
    pick      = {CHW{1'b0}};
    for (int i = NCH - 1; i >= 0; i--) begin
      ready[i]  = enabled[i] & ~(ctrl_wr & (ch_sel == CHW'(i))) &
                  (mode[i] ? ((hstate[i] == H_WAIT) & (bus.lcd_mode == 2'd0))
                           : (remaining[i] != 8'd0));
      any_ready = any_ready | ready[i];
      pick      = ready[i] ? CHW'(i) : pick;
    end
  end

  // Combinational register read-back.
  always_comb begin
    rdata = 8'hFF;
    if (bus.sel_reg && ch_ok) begin
      case (reg_sel)
        4'd1:    rdata = src_h[ch_sel];
        4'd2:    rdata = {src_l[ch_sel], 4'h0};
        4'd3:    rdata = {3'b100, dst_h[ch_sel]};
        4'd4:    rdata = {dst_l[ch_sel], 4'h0};
        4'd5:    rdata = {~enabled[ch_sel], remaining[ch_sel][6:0] - 7'd1};
        default: rdata = 8'hFF;
      endcase
    end else begin
      rdata = 8'hFF;
    end
  end

  // Per-channel registers, working counters and H-Blank sequencing.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (reset) begin
        src_h[i]     <= 8'hFF;
        src_l[i]     <= 4'hF;
        dst_h[i]     <= 5'h1F;
        dst_l[i]     <= 4'hF;
        enabled[i]   <= 1'b0;
        mode[i]      <= 1'b0;
        remaining[i] <= 8'h80;
        hstate[i]    <= H_WAIT;
        work_src[i]  <= 16'h0000;
        work_dst[i]  <= 13'h0000;
      end else begin
        if (hstate[i] == H_SENT && bus.lcd_mode == 2'd3) begin
          hstate[i] <= H_WAIT;
        end
        if (state == E_IDLE && any_ready && pick == CHW'(i)) begin
          hstate[i] <= H_ACTIVE;
        end
        if (byte_done && cur_ch == CHW'(i)) begin
          work_src[i] <= work_src[i] + 16'd1;
          work_dst[i] <= work_dst[i] + 13'd1;
        end
        if (blk_done && cur_ch == CHW'(i)) begin
          hstate[i] <= H_SENT;
          if (remaining[i] == 8'd1) begin
            enabled[i]   <= 1'b0;
            remaining[i] <= 8'h80;
          end else begin
            remaining[i] <= remaining[i] - 8'd1;
          end
        end
        if (wr_en && ch_sel == CHW'(i)) begin
          case (reg_sel)
            4'd1: src_h[i] <= bus.din;
            4'd2: src_l[i] <= bus.din[7:4];
            4'd3: dst_h[i] <= bus.din[4:0];
            4'd4: dst_l[i] <= bus.din[7:4];
            4'd5: begin
              if (cancel) begin
                enabled[i] <= 1'b0;
                hstate[i]  <= H_WAIT;
              end else if (trigger) begin
                enabled[i]   <= 1'b1;
                mode[i]      <= bus.din[7];
                remaining[i] <= {1'b0, bus.din[6:0]} + 8'd1;
                work_src[i]  <= {src_h[i], src_l[i], 4'h0};
                work_dst[i]  <= {dst_h[i], dst_l[i], 4'h0};
                hstate[i]    <= H_WAIT;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  // Shared copy engine: grant, byte pacing, block end; holds last shown addresses when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= E_IDLE;
      rd       <= 1'b0;
      cur_ch   <= {CHW{1'b0}};
      sub      <= {SW{1'b0}};
      bcnt     <= {BW{1'b0}};
      src_hold <= 16'h0000;
      dst_hold <= 16'h0000;
    end else begin
      if (rd) begin
        src_hold <= work_src[cur_ch];
        dst_hold <= {3'b100, work_dst[cur_ch]};
      end
      case (state)
        E_IDLE: begin
          sub  <= {SW{1'b0}};
          bcnt <= {BW{1'b0}};
          if (any_ready) begin
            state  <= E_XFER;
            rd     <= 1'b1;
            cur_ch <= pick;
          end else begin
            rd <= 1'b0;
          end
        end
        E_XFER: begin
          if (cancel_granted || blk_done) begin
            state <= E_IDLE;
            rd    <= 1'b0;
          end else if (step) begin
            sub <= byte_done ? {SW{1'b0}} : sub + SW'(1);
            if (byte_done) begin
              bcnt <= bcnt + BW'(1);
            end
          end
        end
        default: begin
          state <= E_IDLE;
          rd    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout             = rdata;
  assign bus.hdma_rd          = rd;
  assign bus.hdma_ch          = cur_ch;
  assign bus.ch_busy          = enabled;
  assign bus.hdma_source_addr = rd ? work_src[cur_ch] : src_hold;
  assign bus.hdma_target_addr = rd ? {3'b100, work_dst[cur_ch]} : dst_hold;
endmodule

// File: tb/tb_hdma_multi.sv
// Directed bench for hdma_multi: per-byte address scoreboard plus burst-length,
// arbitration, stall, cancel, wrap and reset checks.
`timescale 1ns/1ps
module tb_hdma_multi;
  localparam int NCH = 2;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] sb [$];
  logic [15:0] prev_s = 16'h0;
  logic [15:0] prev_t = 16'h0;
  bit          prev_rd = 1'b0;

  hdma_multi_if #(.NCH(NCH)) bus ();
  hdma_multi #(.NCH(NCH), .BLOCK_BYTES(16), .CYC_PER_BYTE(2)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wreg(input int ch, input int r, input logic [7:0] d);
    bus.addr = 5'((ch << 4) | r);
    bus.din = d;
    bus.sel_reg = 1'b1;
    bus.wr = 1'b1;
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
    bus.sel_reg = 1'b0;
  endtask

  task automatic rreg(input int ch, input int r, output logic [7:0] d);
    bus.addr = 5'((ch << 4) | r);
    bus.sel_reg = 1'b1;
    #1;
    d = bus.dout;
    bus.sel_reg = 1'b0;
  endtask

  task automatic set_regs(input int ch, input logic [15:0] src, input logic [15:0] dst);
    wreg(ch, 1, src[15:8]);
    wreg(ch, 2, src[7:0]);
    wreg(ch, 3, dst[15:8]);
    wreg(ch, 4, dst[7:0]);
  endtask

  // Expected per-byte addresses: source wraps at 16 bits, target stays in 8000-9FFF.
  task automatic push_bytes(input logic [15:0] src, input logic [15:0] dst, input int n);
    logic [15:0] s;
    logic [15:0] t;
    for (int k = 0; k < n; k++) begin
      s = src + 16'(k);
      t = 16'h8000 | ((dst - 16'h8000 + 16'(k)) & 16'h1FFF);
      sb.push_back({s, t});
    end
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (bus.hdma_rd === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_low(output int n, input int limit);
    n = 0;
    while (bus.hdma_rd !== 1'b1 && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Every new address pair shown while hdma_rd is high is one transferred byte.
  always @(negedge clk) begin
    logic [31:0] e;
    if (bus.hdma_rd === 1'b1 &&
        (!prev_rd || bus.hdma_source_addr !== prev_s || bus.hdma_target_addr !== prev_t)) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("byte_addr", {bus.hdma_source_addr, bus.hdma_target_addr}, e);
      end
    end
    prev_rd = (bus.hdma_rd === 1'b1);
    prev_s  = bus.hdma_source_addr;
    prev_t  = bus.hdma_target_addr;
  end

  initial begin
    logic [7:0] d;
    logic [7:0] hexp [3];
    logic [15:0] cap_s;
    logic [15:0] cap_t;
    int n;
    hexp = '{8'h01, 8'h00, 8'hFF};
    bus.sel_reg = 1'b0;
    bus.wr = 1'b0;
    bus.addr = 5'd0;
    bus.din = 8'h00;
    bus.lcd_mode = 2'd2;
    bus.dma_wait = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_rd", 32'(bus.hdma_rd), 32'd0);
    check("rst_ch", 32'(bus.hdma_ch), 32'd0);
    check("rst_busy", 32'(bus.ch_busy), 32'd0);
    check("rst_src_addr", 32'(bus.hdma_source_addr), 32'h0);
    check("rst_tgt_addr", 32'(bus.hdma_target_addr), 32'h0);
    rreg(1, 1, d); check("rst_src_h", 32'(d), 32'hFF);
    rreg(1, 2, d); check("rst_src_l", 32'(d), 32'hF0);
    rreg(1, 3, d); check("rst_dst_h", 32'(d), 32'h9F);
    rreg(0, 4, d); check("rst_dst_l", 32'(d), 32'hF0);
    rreg(0, 5, d); check("rst_ctrl", 32'(d), 32'hFF);
    rreg(0, 7, d); check("rd_unmapped", 32'(d), 32'hFF);
    reset = 1'b0;
    @(negedge clk);

    // GDMA, two blocks on ch0
    set_regs(0, 16'h2040, 16'h8200);
    rreg(0, 3, d); check("g_dst_h_rb", 32'(d), 32'h82);
    push_bytes(16'h2040, 16'h8200, 32);
    wreg(0, 5, 8'h01);
    rreg(0, 5, d); check("g_ctrl_armed", 32'(d), 32'h01);
    @(negedge clk); check("g_lat_t1", 32'(bus.hdma_rd), 32'd0);
    @(negedge clk); check("g_lat_t2", 32'(bus.hdma_rd), 32'd1);
    check("g_ch", 32'(bus.hdma_ch), 32'd0);
    count_high(n); check("g_blk1_len", 32'(n), 32'd32);
    count_low(n, 20); check("g_gap", 32'(n), 32'd1);
    count_high(n); check("g_blk2_len", 32'(n), 32'd32);
    check("g_src_hold", 32'(bus.hdma_source_addr), 32'h205F);
    check("g_tgt_hold", 32'(bus.hdma_target_addr), 32'h821F);
    rreg(0, 5, d); check("g_ctrl_done", 32'(d), 32'hFF);
    check("g_busy_done", 32'(bus.ch_busy), 32'd0);
    check("g_sb_empty", 32'(sb.size()), 32'd0);

    // HDMA, three blocks on ch0: one burst per H-Blank
    set_regs(0, 16'h3000, 16'h8400);
    push_bytes(16'h3000, 16'h8400, 48);
    wreg(0, 5, 8'h82);
    rreg(0, 5, d); check("h_ctrl_armed", 32'(d), 32'h02);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      bus.lcd_mode = 2'd0;
      count_low(n, 10); check("h_start", 32'(bus.hdma_rd), 32'd1);
      count_high(n); check("h_burst_len", 32'(n), 32'd32);
      n = 0;
      repeat (8) begin
        @(negedge clk);
        if (bus.hdma_rd === 1'b1) n++;
      end
      check("h_one_per_hblank", 32'(n), 32'd0);
      rreg(0, 5, d); check("h_ctrl_after", 32'(d), 32'(hexp[b]));
      bus.lcd_mode = 2'd2;
      repeat (3) @(negedge clk);
      bus.lcd_mode = 2'd3;
      repeat (3) @(negedge clk);
    end
    bus.lcd_mode = 2'd2;
    check("h_sb_empty", 32'(sb.size()), 32'd0);

    // HDMA on ch1, cancelled after its first block
    set_regs(1, 16'h4000, 16'h8800);
    push_bytes(16'h4000, 16'h8800, 16);
    wreg(1, 5, 8'h82);
    @(negedge clk);
    bus.lcd_mode = 2'd0;
    count_low(n, 10);
    count_high(n); check("c_burst_len", 32'(n), 32'd32);
    @(negedge clk);
    bus.lcd_mode = 2'd2;
    wreg(1, 5, 8'h00);
    rreg(1, 5, d); check("c_ctrl_cancel", 32'(d), 32'h81);
    check("c_busy", 32'(bus.ch_busy), 32'd0);
    @(negedge clk);
    bus.lcd_mode = 2'd3;
    repeat (3) @(negedge clk);
    bus.lcd_mode = 2'd0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.hdma_rd === 1'b1) n++;
    end
    check("c_no_more_bursts", 32'(n), 32'd0);
    bus.lcd_mode = 2'd2;
    check("c_sb_empty", 32'(sb.size()), 32'd0);

    // ch0 GDMA and ch1 HDMA become ready in the same cycle
    set_regs(1, 16'h5000, 16'h8A00);
    wreg(1, 5, 8'h80);
    set_regs(0, 16'h6000, 16'h8C00);
    push_bytes(16'h6000, 16'h8C00, 16);
    push_bytes(16'h5000, 16'h8A00, 16);
    wreg(0, 5, 8'h00);
    bus.lcd_mode = 2'd0;
    @(negedge clk); check("a_lat_t1", 32'(bus.hdma_rd), 32'd0);
    @(negedge clk); check("a_lat_t2", 32'(bus.hdma_rd), 32'd1);
    check("a_first_ch0", 32'(bus.hdma_ch), 32'd0);
    count_high(n); check("a_ch0_len", 32'(n), 32'd32);
    count_low(n, 20); check("a_gap", 32'(n), 32'd1);
    check("a_then_ch1", 32'(bus.hdma_ch), 32'd1);
    count_high(n); check("a_ch1_len", 32'(n), 32'd32);
    bus.lcd_mode = 2'd2;
    rreg(1, 5, d); check("a_ch1_ctrl", 32'(d), 32'hFF);
    check("a_busy", 32'(bus.ch_busy), 32'd0);
    check("a_sb_empty", 32'(sb.size()), 32'd0);

    // dma_wait held for 5 cycles mid-byte
    set_regs(0, 16'h7000, 16'h8E00);
    push_bytes(16'h7000, 16'h8E00, 16);
    wreg(0, 5, 8'h00);
    count_low(n, 10); check("w_start", 32'(bus.hdma_rd), 32'd1);
    n = 0;
    cap_s = 16'h0;
    cap_t = 16'h0;
    while (bus.hdma_rd === 1'b1 && n < 200) begin
      n++;
      if (n == 8) begin
        cap_s = bus.hdma_source_addr;
        cap_t = bus.hdma_target_addr;
        check("w_cap_src", 32'(cap_s), 32'h7003);
        bus.dma_wait = 1'b1;
      end
      if (n == 13) begin
        check("w_frozen_src", 32'(bus.hdma_source_addr), 32'(cap_s));
        check("w_frozen_tgt", 32'(bus.hdma_target_addr), 32'(cap_t));
        bus.dma_wait = 1'b0;
      end
      @(negedge clk);
    end
    check("w_burst_len", 32'(n), 32'd37);
    check("w_sb_empty", 32'(sb.size()), 32'd0);

    // Source and target wrap, then reset in the middle of the second block
    set_regs(0, 16'hFFF0, 16'h9FF0);
    push_bytes(16'hFFF0, 16'h9FF0, 20);
    wreg(0, 5, 8'h01);
    count_low(n, 10);
    count_high(n); check("x_blk1_len", 32'(n), 32'd32);
    count_low(n, 20); check("x_gap", 32'(n), 32'd1);
    repeat (7) @(negedge clk);
    check("x_tgt_wrap", 32'(bus.hdma_target_addr), 32'h8003);
    check("x_src_wrap", 32'(bus.hdma_source_addr), 32'h0003);
    reset = 1'b1;
    @(negedge clk);
    check("x_rst_rd", 32'(bus.hdma_rd), 32'd0);
    check("x_rst_src_addr", 32'(bus.hdma_source_addr), 32'h0);
    check("x_rst_busy", 32'(bus.ch_busy), 32'd0);
    rreg(0, 5, d); check("x_rst_ctrl", 32'(d), 32'hFF);
    rreg(0, 1, d); check("x_rst_src_h", 32'(d), 32'hFF);
    check("x_sb_empty", 32'(sb.size()), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
